// File: rtl/operand_fetch.sv
// Operand fetch stage: reads GPREGS, bypasses same-cycle writeback, tracks pending
// destination registers in a busy scoreboard and presents a registered ID/EX entry.
module operand_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [4:0]            in_rd,
    input  logic                  in_rd_enable,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  flush,
    input  logic                  wb_enable,
    input  logic [4:0]            wb_reg,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [4:0]            read_reg_0,
    output logic [4:0]            read_reg_1,
    input  logic [DATA_WIDTH-1:0] dout_reg_0,
    input  logic [DATA_WIDTH-1:0] dout_reg_1,
    output logic [4:0]            write_reg,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  din_enable,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_op1,
    output logic [DATA_WIDTH-1:0] out_op2,
    output logic [4:0]            out_rd,
    output logic                  out_rd_enable,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  hazard_stall
);

    logic [31:0]           busy_reg;
    logic [31:0]           busy_next;
    logic [31:0]           wb_clear;
    logic [31:0]           src_ready;
    logic [31:0]           busy_set;
    logic [31:0]           busy_release;

    logic                  out_valid_reg;
    logic [DATA_WIDTH-1:0] out_op1_reg;
    logic [DATA_WIDTH-1:0] out_op2_reg;
    logic [4:0]            out_rd_reg;
    logic                  out_rd_enable_reg;
    logic [DATA_WIDTH-1:0] out_pc_reg;
    logic [DATA_WIDTH-1:0] out_imm_reg;
    logic [CTRL_WIDTH-1:0] out_ctrl_reg;

    logic                  hazard;
    logic                  accept;
    logic [DATA_WIDTH-1:0] op1_next;
    logic [DATA_WIDTH-1:0] op2_next;

    // GPREGS write port is a straight pass-through of the writeback bus.
    assign read_reg_0 = in_rs1;
    assign read_reg_1 = in_rs2;
    assign write_reg  = wb_reg;
    assign din        = wb_data;
    assign din_enable = wb_enable;

    // x0 never becomes busy, so it is always ready and never bypassed.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_sb
            if (gi == 0) begin : g_zero
                assign wb_clear[gi]     = 1'b0;
                assign src_ready[gi]    = 1'b1;
                assign busy_set[gi]     = 1'b0;
                assign busy_release[gi] = 1'b0;
                assign busy_next[gi]    = 1'b0;
            end else begin : g_reg
                assign wb_clear[gi]     = wb_enable && (wb_reg == 5'(gi));
                assign src_ready[gi]    = !busy_reg[gi] || wb_clear[gi];
                assign busy_set[gi]     = accept && in_rd_enable && (in_rd == 5'(gi));
                assign busy_release[gi] = flush && out_valid_reg && out_rd_enable_reg &&
                                          (out_rd_reg == 5'(gi));
                assign busy_next[gi]    = busy_set[gi] ? 1'b1 :
                                          (busy_release[gi] || wb_clear[gi]) ? 1'b0 :
                                          busy_reg[gi];
            end
        end
    endgenerate

    assign hazard   = in_valid && !(src_ready[in_rs1] && src_ready[in_rs2] &&
                                    (!in_rd_enable || src_ready[in_rd]));
    assign in_ready = !hazard && !flush && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;
    assign hazard_stall = hazard;

    assign op1_next = (in_rs1 == 5'd0) ? '0 : wb_clear[in_rs1] ? wb_data : dout_reg_0;
    assign op2_next = (in_rs2 == 5'd0) ? '0 : wb_clear[in_rs2] ? wb_data : dout_reg_1;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg          <= '0;
            out_valid_reg     <= 1'b0;
            out_op1_reg       <= '0;
            out_op2_reg       <= '0;
            out_rd_reg        <= '0;
            out_rd_enable_reg <= 1'b0;
            out_pc_reg        <= '0;
            out_imm_reg       <= '0;
            out_ctrl_reg      <= '0;
        end else begin
            busy_reg <= busy_next;
            if (accept) begin
                out_valid_reg     <= 1'b1;
                out_op1_reg       <= op1_next;
                out_op2_reg       <= op2_next;
                out_rd_reg        <= in_rd;
                out_rd_enable_reg <= in_rd_enable;
                out_pc_reg        <= in_pc;
                out_imm_reg       <= in_imm;
                out_ctrl_reg      <= in_ctrl;
            end else if (flush || out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid     = out_valid_reg;
    assign out_op1       = out_op1_reg;
    assign out_op2       = out_op2_reg;
    assign out_rd        = out_rd_reg;
    assign out_rd_enable = out_rd_enable_reg;
    assign out_pc        = out_pc_reg;
    assign out_imm       = out_imm_reg;
    assign out_ctrl      = out_ctrl_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus random traffic, all checked every cycle
// against a pending-register-set / output-slot model of the stage.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_rd_enable;
    logic [31:0] in_pc, in_imm;
    logic [15:0] in_ctrl;
    logic        flush, wb_enable;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [4:0]  read_reg_0, read_reg_1, write_reg;
    logic [31:0] dout_reg_0, dout_reg_1, din;
    logic        din_enable, out_valid, out_ready;
    logic [31:0] out_op1, out_op2, out_pc, out_imm;
    logic [4:0]  out_rd;
    logic        out_rd_enable;
    logic [15:0] out_ctrl;
    logic        hazard_stall;

    int n_checks = 0;
    int n_fail   = 0;

    // GPREGS stand-in: combinational read, written by the model from the writeback bus.
    logic [31:0] gpr [32];
    assign dout_reg_0 = gpr[read_reg_0];
    assign dout_reg_1 = gpr[read_reg_1];

    // Model state: registers with a write still outstanding, and the output slot.
    bit          m_pending [32];
    bit          m_ov;
    logic [31:0] m_op1, m_op2, m_pc, m_imm;
    logic [4:0]  m_rd;
    bit          m_rd_en;
    logic [15:0] m_ctrl;

    always #5 clk = ~clk;

    operand_fetch #(.DATA_WIDTH(32), .CTRL_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_enable(in_rd_enable),
        .in_pc(in_pc), .in_imm(in_imm), .in_ctrl(in_ctrl),
        .flush(flush), .wb_enable(wb_enable), .wb_reg(wb_reg), .wb_data(wb_data),
        .read_reg_0(read_reg_0), .read_reg_1(read_reg_1),
        .dout_reg_0(dout_reg_0), .dout_reg_1(dout_reg_1),
        .write_reg(write_reg), .din(din), .din_enable(din_enable),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_rd_enable(out_rd_enable),
        .out_pc(out_pc), .out_imm(out_imm), .out_ctrl(out_ctrl),
        .hazard_stall(hazard_stall)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit avail(input logic [4:0] r);
        return (r == 5'd0) || !m_pending[r] || (wb_enable && wb_reg == r);
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_enable && wb_reg == r) return wb_data;
        return gpr[r];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_pending[i] = 1'b0;
        m_ov = 0; m_op1 = '0; m_op2 = '0; m_pc = '0; m_imm = '0;
        m_rd = '0; m_rd_en = 0; m_ctrl = '0;
    endtask

    task automatic idle();
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_enable = 0;
        in_pc = 0; in_imm = 0; in_ctrl = 0; flush = 0;
        wb_enable = 0; wb_reg = 0; wb_data = 0; out_ready = 1;
    endtask

    // One clock: compare everything at the falling edge, then advance the model.
    task automatic step();
        bit exp_hz, exp_rdy, acc;
        logic [31:0] op1, op2;
        @(negedge clk);
        exp_hz  = in_valid && !(avail(in_rs1) && avail(in_rs2) &&
                                (!in_rd_enable || avail(in_rd)));
        exp_rdy = !exp_hz && !flush && (!m_ov || out_ready);
        chk("hazard_stall", hazard_stall, exp_hz);
        chk("in_ready", in_ready, exp_rdy);
        chk("read_reg_0", read_reg_0, in_rs1);
        chk("read_reg_1", read_reg_1, in_rs2);
        chk("write_reg", write_reg, wb_reg);
        chk("din", din, wb_data);
        chk("din_enable", din_enable, wb_enable);
        chk("out_valid", out_valid, m_ov);
        chk("out_op1", out_op1, m_op1);
        chk("out_op2", out_op2, m_op2);
        chk("out_rd", out_rd, m_rd);
        chk("out_rd_enable", out_rd_enable, m_rd_en);
        chk("out_pc", out_pc, m_pc);
        chk("out_imm", out_imm, m_imm);
        chk("out_ctrl", out_ctrl, m_ctrl);
        if (out_valid && out_ready && !reset)
            $display("xfer pc=%08h op1=%08h op2=%08h rd=%0d/%0b", out_pc, out_op1, out_op2,
                     out_rd, out_rd_enable);
        acc = in_valid && exp_rdy;
        op1 = operand(in_rs1);
        op2 = operand(in_rs2);
        @(posedge clk);
        #1;
        if (reset) begin
            model_clear();
        end else begin
            // Retire the writeback, drop the flushed entry's claim, then claim the new rd.
            if (wb_enable && wb_reg != 5'd0) m_pending[wb_reg] = 1'b0;
            if (flush && m_ov && m_rd_en) m_pending[m_rd] = 1'b0;
            if (acc && in_rd_enable && in_rd != 5'd0) m_pending[in_rd] = 1'b1;
            if (acc) begin
                m_ov = 1; m_op1 = op1; m_op2 = op2; m_pc = in_pc; m_imm = in_imm;
                m_rd = in_rd; m_rd_en = in_rd_enable; m_ctrl = in_ctrl;
            end else if (flush || out_ready) begin
                m_ov = 0;
            end
        end
        if (wb_enable) gpr[wb_reg] = wb_data;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rd_en, input logic [31:0] pc);
        in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_enable = rd_en;
        in_pc = pc; in_imm = pc ^ 32'h5555_0000; in_ctrl = pc[15:0];
    endtask

    initial begin
        int pick;
        for (int i = 0; i < 32; i++) gpr[i] = $urandom;
        gpr[0] = 32'hDEAD_BEEF;
        idle();
        reset = 1;
        model_clear();
        @(posedge clk); #1;
        step();
        reset = 0;

        // 1: x0 sources read as zero, one-cycle latency
        issue(0, 0, 0, 0, 32'h100);
        #1 chk("t1_in_ready", in_ready, 1);
        step();
        chk("t1_out_valid", out_valid, 1);
        chk("t1_op1", out_op1, 0);
        chk("t1_op2", out_op2, 0);
        chk("t1_pc", out_pc, 32'h100);

        // 2: same-cycle writeback bypass
        issue(5, 0, 0, 0, 32'h200);
        wb_enable = 1; wb_reg = 5; wb_data = 32'h12;
        #1 chk("t2_din_enable", din_enable, 1);
        step();
        wb_enable = 0;
        chk("t2_op1", out_op1, 32'h12);

        // 3: RAW stall until x3 retires
        issue(0, 0, 3, 1, 32'h300);
        step();
        issue(0, 3, 0, 0, 32'h301);
        #1 chk("t3_stall", hazard_stall, 1);
        chk("t3_in_ready", in_ready, 0);
        step();
        #1 chk("t3_stall2", hazard_stall, 1);
        step();
        wb_enable = 1; wb_reg = 3; wb_data = 32'hAB;
        #1 chk("t3_release", in_ready, 1);
        step();
        wb_enable = 0;
        chk("t3_op2", out_op2, 32'hAB);
        chk("t3_pc", out_pc, 32'h301);
        issue(3, 0, 0, 0, 32'h302);
        #1 chk("t3_busy_cleared", hazard_stall, 0);
        step();

        // 4: backpressure holds the output entry
        out_ready = 0;
        issue(1, 2, 0, 0, 32'h400);
        for (int k = 0; k < 3; k++) begin
            #1 chk("t4_in_ready", in_ready, 0);
            step();
            chk("t4_out_valid", out_valid, 1);
            chk("t4_pc_hold", out_pc, 32'h302);
        end
        out_ready = 1;
        step();

        // 5: flush kills the entry and releases its rd
        issue(0, 0, 7, 1, 32'h500);
        step();
        flush = 1;
        issue(0, 0, 0, 0, 32'h501);
        #1 chk("t5_in_ready", in_ready, 0);
        step();
        flush = 0;
        chk("t5_out_valid", out_valid, 0);
        issue(7, 0, 0, 0, 32'h502);
        #1 chk("t5_no_stall", hazard_stall, 0);
        step();
        chk("t5_pc", out_pc, 32'h502);

        // 6: new claim wins over a same-cycle writeback of that register
        issue(0, 0, 4, 1, 32'h600);
        wb_enable = 1; wb_reg = 4; wb_data = 32'h44;
        step();
        wb_enable = 0;
        issue(4, 0, 0, 0, 32'h601);
        #1 chk("t6_busy_set", hazard_stall, 1);
        step();
        wb_enable = 1; wb_reg = 4; wb_data = 32'h45;
        step();
        chk("t6_op1", out_op1, 32'h45);
        idle();
        step();

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            reset        = ($urandom_range(0, 499) == 0);
            in_valid     = ($urandom_range(0, 9) < 7);
            in_rs1       = 5'($urandom_range(0, 7));
            in_rs2       = 5'($urandom_range(0, 7));
            in_rd        = 5'($urandom_range(0, 7));
            in_rd_enable = ($urandom_range(0, 9) < 6);
            in_pc        = $urandom;
            in_imm       = $urandom;
            in_ctrl      = 16'($urandom);
            flush        = ($urandom_range(0, 19) == 0);
            out_ready    = ($urandom_range(0, 9) < 7);
            wb_enable    = ($urandom_range(0, 9) < 4);
            wb_data      = $urandom;
            wb_reg       = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) begin
                pick = $urandom_range(0, 31);
                for (int k = 0; k < 32; k++)
                    if (m_pending[(pick + k) % 32]) begin
                        wb_reg = 5'((pick + k) % 32);
                        break;
                    end
            end
            step();
        end

        // Drain: retire everything still pending
        idle();
        reset = 0;
        for (int c = 0; c < 40; c++) begin
            for (int k = 1; k < 32; k++)
                if (m_pending[k]) begin
                    wb_enable = 1; wb_reg = 5'(k); wb_data = $urandom;
                    break;
                end
            step();
            wb_enable = 0;
        end
        issue(1, 2, 3, 1, 32'h700);
        #1 chk("drain_no_stall", hazard_stall, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
